wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back end of the five-stage integer pipeline: consumes the write-back bundle that leaves the MEM/WB pipeline register and commits it to architectural state. Holds the 32 x 32-bit general-purpose register file plus the HI/LO register pair. Exposes two read ports for the ID stage and a HI/LO read port for the EX stage. Optional same-cycle write-to-read bypass closes the WB-to-ID hazard window.

## Interface
- No parameters; widths fixed: data 32, register address 5.
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- wb_wreg  in  1  GPR write enable from write-back
- wb_wd  in  5  GPR destination address
- wb_wdata  in  32  GPR write data
- wb_whilo  in  1  HI/LO write enable
- wb_hi  in  32  HI write data
- wb_lo  in  32  LO write data
- re1  in  1  read-port-1 enable
- raddr1  in  5  read-port-1 address
- rdata1  out  32  read-port-1 data, combinational
- re2  in  1  read-port-2 enable
- raddr2  in  5  read-port-2 address
- rdata2  out  32  read-port-2 data, combinational
- hi_o  out  32  current HI, combinational
- lo_o  out  32  current LO, combinational

## Operation
- Storage: gpr[1..31], hi_q, lo_q. gpr[0] not stored; register $0 reads 0 always.
- Reset (rst=0, asynchronous, no clock needed): gpr[1..31], hi_q, lo_q cleared to 0. While rst=0, rdata1, rdata2, hi_o, lo_o are forced to 0 regardless of other inputs.
- GPR write: rising clk with rst=1, wb_wreg=1, wb_wd!=0 -> gpr[wb_wd] <= wb_wdata. Write to $0 discarded (no state change).
- HI/LO write: rising clk with rst=1, wb_whilo=1 -> hi_q <= wb_hi and lo_q <= wb_lo together; no partial HI-only/LO-only write.
- GPR and HI/LO writes independent; both may commit on the same edge.
- Read port n (n=1,2), priority order:
  - re_n=0 -> rdata_n = 0.
  - raddr_n=0 -> 0.
  - bypass hit (see Configuration) -> wb_wdata.
  - else gpr[raddr_n].
- Both ports may address the same register, including the one being written; each resolves independently.
- hi_o/lo_o: bypass hit when wb_whilo=1 -> wb_hi/wb_lo; else hi_q/lo_q.
- No X propagation: all outputs fully defined for every input combination once out of reset.

## Timing
- Write latency: data presented on wb_* is in storage after the next rising clk edge; visible from stored path from that edge.
- Read latency: zero cycles, purely combinational from raddr/re and state.
- Reset assertion mid-cycle clears state immediately; a write edge coinciding with rst=0 is lost.
- Reset deassertion: first write can commit on the first rising edge with rst=1.
- No handshake; wb_* bundle is valid every cycle it is presented (MEM/WB register holds wb_wreg=0, wb_whilo=0 during its own reset).

## Configuration
- Macro WB_REGFILE_BYPASS_EN.
- Defined: read port n hits when wb_wreg=1, wb_wd==raddr_n, raddr_n!=0, re_n=1 -> returns wb_wdata same cycle; hi_o/lo_o return wb_hi/wb_lo when wb_whilo=1. ID observes an in-flight WB result without a stall.
- Undefined: no bypass; reads always return stored state, new value visible only after the write edge. Pipeline must cover the one-cycle gap (stall or compiler spacing).

## Test plan
- Reset: write gpr[5]=0x12345678, assert rst=0 between edges -> rdata1 (re1=1, raddr1=5) 0 immediately; after release still 0; hi_o=lo_o=0.
- Write/read: wb_wreg=1, wb_wd=7, wb_wdata=0xDEADBEEF, edge -> raddr1=7, raddr2=7 both read 0xDEADBEEF; re2=0 -> rdata2=0.
- $0 protection: wb_wreg=1, wb_wd=0, wb_wdata=0xFFFFFFFF, edge -> raddr1=0 reads 0; no other register changed.
- Bypass: gpr[3]=0x1, same cycle wb_wd=3, wb_wdata=0xA5A5A5A5, wb_wreg=1, raddr1=3 -> with WB_REGFILE_BYPASS_EN rdata1=0xA5A5A5A5 before edge; without, 0x1 before edge, 0xA5A5A5A5 after.
- HI/LO: wb_whilo=1, wb_hi=0x00000002, wb_lo=0x80000000, edge -> hi_o=0x2, lo_o=0x80000000; wb_whilo=0 with new data -> unchanged.
- Simultaneous: same edge wb_wreg=1 wd=31 wdata=0x55 and wb_whilo=1 hi=0x11 lo=0x22 -> gpr[31]=0x55, hi_o=0x11, lo_o=0x22.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back register file: 31 stored GPRs ($0 hardwired to zero) plus the HI/LO pair.
// Define WB_REGFILE_BYPASS_EN to forward the in-flight write-back data to the read ports in the same cycle.
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_wreg,
  input  logic [4:0]  wb_wd,
  input  logic [31:0] wb_wdata,
  input  logic        wb_whilo,
  input  logic [31:0] wb_hi,
  input  logic [31:0] wb_lo,
  input  logic        re1,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic        re2,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

`ifdef WB_REGFILE_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  logic [31:0] gpr_q [1:31];
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        gpr_we;

  assign gpr_we = wb_wreg && (wb_wd != 5'd0);

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (wb_whilo) begin
      hi_d = wb_hi;
      lo_d = wb_lo;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < 32; i++) gpr_q[i] <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (gpr_we) gpr_q[wb_wd] <= wb_wdata;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Outputs are held at zero while reset is asserted, independent of the clock.
  always_comb begin
    rdata1 = '0;
    if (rst && re1 && (raddr1 != 5'd0)) begin
      if (BYPASS && wb_wreg && (wb_wd == raddr1)) rdata1 = wb_wdata;
      else                                        rdata1 = gpr_q[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (rst && re2 && (raddr2 != 5'd0)) begin
      if (BYPASS && wb_wreg && (wb_wd == raddr2)) rdata2 = wb_wdata;
      else                                        rdata2 = gpr_q[raddr2];
    end
  end

  always_comb begin
    hi_o = '0;
    lo_o = '0;
    if (rst) begin
      if (BYPASS && wb_whilo) begin
        hi_o = wb_hi;
        lo_o = wb_lo;
      end else begin
        hi_o = hi_q;
        lo_o = lo_q;
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: architectural model checked on every falling edge, plus literal spot checks.
module tb_wb_regfile;

`ifdef WB_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_wreg = 1'b0;
  logic [4:0]  wb_wd = '0;
  logic [31:0] wb_wdata = '0;
  logic        wb_whilo = 1'b0;
  logic [31:0] wb_hi = '0;
  logic [31:0] wb_lo = '0;
  logic        re1 = 1'b0;
  logic [4:0]  raddr1 = '0;
  logic [31:0] rdata1;
  logic        re2 = 1'b0;
  logic [4:0]  raddr2 = '0;
  logic [31:0] rdata2;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int failures = 0;
  bit model_on = 1'b0;

  logic [31:0] m_gpr [0:31];
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  // Architectural state as a plain array; $0 is never written.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = '0;
      m_hi = '0;
      m_lo = '0;
    end else begin
      if (wb_wreg && wb_wd != 5'd0) m_gpr[wb_wd] = wb_wdata;
      if (wb_whilo) begin
        m_hi = wb_hi;
        m_lo = wb_lo;
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic en, input logic [4:0] a);
    if (!rst || !en || a == 5'd0) return 32'h0;
    if (BYP && wb_wreg && wb_wd == a) return wb_wdata;
    return m_gpr[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      check("cmp_rdata1", rdata1, exp_rd(re1, raddr1));
      check("cmp_rdata2", rdata2, exp_rd(re2, raddr2));
      check("cmp_hi", hi_o, (!rst) ? 32'h0 : (BYP && wb_whilo) ? wb_hi : m_hi);
      check("cmp_lo", lo_o, (!rst) ? 32'h0 : (BYP && wb_whilo) ? wb_lo : m_lo);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_on = 1'b1;
    re1 = 1'b1; raddr1 = 5'd5;
    #1;
    check("reset_rdata1", rdata1, 32'h0);
    check("reset_hi", hi_o, 32'h0);
    cyc(); cyc();
    rst = 1'b1;

    // Reset clears state between edges
    wb_wreg = 1'b1; wb_wd = 5'd5; wb_wdata = 32'h12345678;
    cyc();
    wb_wreg = 1'b0;
    #1 check("gpr5_written", rdata1, 32'h12345678);
    rst = 1'b0;
    #1 check("midrst_rdata1", rdata1, 32'h0);
    check("midrst_lo", lo_o, 32'h0);
    rst = 1'b1;
    #1 check("postrst_rdata1", rdata1, 32'h0);
    check("postrst_hi", hi_o, 32'h0);
    check("postrst_lo", lo_o, 32'h0);

    // Write and read on both ports
    wb_wreg = 1'b1; wb_wd = 5'd7; wb_wdata = 32'hDEADBEEF;
    cyc();
    wb_wreg = 1'b0;
    raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
    #1 check("rd1_7", rdata1, 32'hDEADBEEF);
    check("rd2_7", rdata2, 32'hDEADBEEF);
    re2 = 1'b0;
    #1 check("rd2_disabled", rdata2, 32'h0);

    // $0 write discarded
    wb_wreg = 1'b1; wb_wd = 5'd0; wb_wdata = 32'hFFFFFFFF;
    cyc();
    wb_wreg = 1'b0;
    raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd7;
    #1 check("r0_zero", rdata1, 32'h0);
    check("r7_kept", rdata2, 32'hDEADBEEF);

    // Same-cycle write/read of $3
    wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 32'h1;
    cyc();
    wb_wdata = 32'hA5A5A5A5; raddr1 = 5'd3;
    #1 check("bypass_pre", rdata1, BYP ? 32'hA5A5A5A5 : 32'h1);
    cyc();
    wb_wreg = 1'b0;
    #1 check("bypass_post", rdata1, 32'hA5A5A5A5);

    // HI/LO
    wb_whilo = 1'b1; wb_hi = 32'h2; wb_lo = 32'h80000000;
    cyc();
    wb_whilo = 1'b0; wb_hi = 32'h1234; wb_lo = 32'h5678;
    #1 check("hi_written", hi_o, 32'h2);
    check("lo_written", lo_o, 32'h80000000);
    cyc();
    check("hi_held", hi_o, 32'h2);
    check("lo_held", lo_o, 32'h80000000);
    wb_whilo = 1'b1; wb_hi = 32'h33;
    #1 check("hi_bypass_pre", hi_o, BYP ? 32'h33 : 32'h2);

    // Simultaneous GPR and HI/LO commit
    wb_wreg = 1'b1; wb_wd = 5'd31; wb_wdata = 32'h55;
    wb_hi = 32'h11; wb_lo = 32'h22;
    cyc();
    wb_wreg = 1'b0; wb_whilo = 1'b0;
    raddr2 = 5'd31;
    #1 check("sim_gpr31", rdata2, 32'h55);
    check("sim_hi", hi_o, 32'h11);
    check("sim_lo", lo_o, 32'h22);

    // Pseudo-random traffic, checked by the falling-edge compare
    for (int i = 0; i < 200; i++) begin
      wb_wreg  = 1'($urandom_range(0, 1));
      wb_wd    = 5'($urandom_range(0, 7));
      wb_wdata = $urandom;
      wb_whilo = ($urandom_range(0, 3) == 0);
      wb_hi    = $urandom;
      wb_lo    = $urandom;
      re1      = ($urandom_range(0, 7) != 0);
      raddr1   = 5'($urandom_range(0, 7));
      re2      = ($urandom_range(0, 7) != 0);
      raddr2   = (i % 3 == 0) ? wb_wd : 5'($urandom_range(0, 31));
      cyc();
    end
    wb_wreg = 1'b0; wb_whilo = 1'b0;
    cyc();
    model_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
